// File: rtl/risc8_pkg.sv
// Shared fetch-stage definitions: widths, HALT opcode field, fetch FSM states.
package risc8_pkg;

  localparam int         PC_W     = 8;
  localparam int         INSTR_W  = 16;
  localparam logic [3:0] OPC_HALT = 4'hF;
  localparam int         OPC_MSB  = 15;
  localparam int         OPC_LSB  = 12;

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  function automatic logic is_halt(input logic [INSTR_W-1:0] instr);
    return instr[OPC_MSB:OPC_LSB] == OPC_HALT;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if_fifo.sv
// Synchronous {pc, instr} buffer with registered head; flush wins over push.
module if_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 24,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [W-1:0]     wdata,
  output logic [W-1:0]     rdata,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             do_push_s, do_pop_s;

  // A full buffer only accepts a push when the head leaves in the same cycle
  always_comb begin
    do_pop_s  = pop & (count_r != {CNT_W{1'b0}});
    do_push_s = push & ((count_r != CNT_W'(DEPTH)) | do_pop_s);
  end

  // Storage, pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= {W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= wdata;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (do_pop_s) rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      count_r <= count_r + CNT_W'(do_push_s) - CNT_W'(do_pop_s);
    end
  end

  assign rdata = mem_r[rd_ptr_r];
  assign count = count_r;
  assign full  = (count_r == CNT_W'(DEPTH));
  assign empty = (count_r == {CNT_W{1'b0}});

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, single-outstanding imem handshake, tagged instruction buffer.
// Define IF_HALT_DETECT_EN to stop fetching after a HALT opcode is buffered.
module instr_fetch_unit #(
  parameter int              PC_W       = risc8_pkg::PC_W,
  parameter int              INSTR_W    = risc8_pkg::INSTR_W,
  parameter int              FIFO_DEPTH = 2,
  parameter logic [PC_W-1:0] RESET_PC   = {PC_W{1'b0}}
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  input  logic               id_ready,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instruction,
  output logic [PC_W-1:0]    if_pc,
  output logic               if_halted
);

  import risc8_pkg::*;

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int ENT_W = PC_W + INSTR_W;

  fetch_state_e     state_r, state_nxt_s;
  logic [PC_W-1:0]  fetch_pc_r, pc_nxt_s, issued_pc_r;
  logic             req_r, halted_r, halted_nxt_s;
  logic             gnt_s, push_s, pop_s, in_flight_s, full_s, empty_s;
  logic [CNT_W-1:0] count_s, count_nxt_s;
  logic [ENT_W-1:0] head_s;

  // Handshake qualifiers and next-state decode; redirect overrides everything
  always_comb begin
    gnt_s       = req_r & imem_gnt;
    pop_s       = ~empty_s & id_ready;
    push_s      = (state_r == WAIT) & imem_rvalid & ~redirect_valid & (~full_s | pop_s);
    // A response is still owed if one was granted and has not yet returned
    in_flight_s = ((state_r != REQ) & ~imem_rvalid) | gnt_s;
    state_nxt_s = REQ;
    if (redirect_valid) begin
      state_nxt_s = in_flight_s ? DRAIN : REQ;
    end else begin
      case (state_r)
        REQ:     state_nxt_s = gnt_s ? WAIT : REQ;
        WAIT:    state_nxt_s = imem_rvalid ? REQ : WAIT;
        DRAIN:   state_nxt_s = imem_rvalid ? REQ : DRAIN;
        default: state_nxt_s = REQ;
      endcase
    end
    if (redirect_valid) pc_nxt_s = redirect_pc;
    else if (gnt_s)     pc_nxt_s = fetch_pc_r + PC_W'(1);
    else                pc_nxt_s = fetch_pc_r;
    count_nxt_s = redirect_valid ? {CNT_W{1'b0}}
                                 : count_s + CNT_W'(push_s) - CNT_W'(pop_s);
`ifdef IF_HALT_DETECT_EN
    if (redirect_valid)                     halted_nxt_s = 1'b0;
    else if (push_s && is_halt(imem_rdata)) halted_nxt_s = 1'b1;
    else                                    halted_nxt_s = halted_r;
`else
    halted_nxt_s = 1'b0;
`endif
  end

  // Fetch FSM, PC and registered request; a slot is reserved for each issued request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= REQ;
      fetch_pc_r  <= RESET_PC;
      issued_pc_r <= RESET_PC;
      req_r       <= 1'b0;
      halted_r    <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      fetch_pc_r <= pc_nxt_s;
      if (gnt_s) issued_pc_r <= fetch_pc_r;
      req_r    <= (state_nxt_s == REQ) && (count_nxt_s < CNT_W'(FIFO_DEPTH)) && !halted_nxt_s;
      halted_r <= halted_nxt_s;
    end
  end

  if_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (ENT_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .pop   (pop_s),
    .flush (redirect_valid),
    .wdata ({issued_pc_r, imem_rdata}),
    .rdata (head_s),
    .count (count_s),
    .full  (full_s),
    .empty (empty_s)
  );

  assign imem_req                = req_r;
  assign imem_addr               = fetch_pc_r;
  assign if_valid                = ~empty_s;
  assign {if_pc, if_instruction} = head_s;
  assign if_halted               = halted_r;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a behavioural instruction memory.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [15:0] imem_rdata;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        id_ready;
  logic        if_valid;
  logic [15:0] if_instruction;
  logic [7:0]  if_pc;
  logic        if_halted;

  int          chk_cnt;
  int          pass_cnt;
  logic [15:0] mem [256];
  logic [23:0] cons_q [$];
  logic [7:0]  grant_q [$];
  logic        gnt_en;
  int          extra_lat;
  logic        pend;
  logic [7:0]  pend_addr;
  int          wait_cnt;

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_ready       (id_ready),
    .if_valid       (if_valid),
    .if_instruction (if_instruction),
    .if_pc          (if_pc),
    .if_halted      (if_halted)
  );

  // Memory: grant when enabled, respond extra_lat cycles after the minimum latency
  initial begin : mem_model
    pend = 1'b0; pend_addr = 8'h00; wait_cnt = 0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 16'h0000;
    forever begin
      @(negedge clk); #1;
      if (!rst_n) begin
        pend = 1'b0; imem_rvalid = 1'b0; imem_gnt = 1'b0;
      end else begin
        imem_rvalid = 1'b0;
        if (pend) begin
          if (wait_cnt == 0) begin
            imem_rvalid = 1'b1; imem_rdata = mem[pend_addr]; pend = 1'b0;
          end else begin
            wait_cnt = wait_cnt - 1;
          end
        end
        imem_gnt = gnt_en;
        if (imem_req && gnt_en && !pend) begin
          pend = 1'b1; pend_addr = imem_addr; wait_cnt = extra_lat;
          grant_q.push_back(imem_addr);
        end
      end
    end
  end

  initial begin : consume_mon
    forever begin
      @(negedge clk); #2;
      if (rst_n && if_valid && id_ready) cons_q.push_back({if_pc, if_instruction});
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst_n = 1'b0; id_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 8'h00;
    gnt_en = 1'b1; extra_lat = 0;
    repeat (3) @(negedge clk);
    chk_cnt++; if (imem_req !== 1'b0) $display("FAIL rst_req: got %0b want 0", imem_req); else pass_cnt++;
    chk_cnt++; if (imem_addr !== 8'h00) $display("FAIL rst_addr: got %h want 00", imem_addr); else pass_cnt++;
    chk_cnt++; if (if_valid !== 1'b0) $display("FAIL rst_valid: got %0b want 0", if_valid); else pass_cnt++;
    chk_cnt++; if (if_instruction !== 16'h0000) $display("FAIL rst_instr: got %h want 0000", if_instruction); else pass_cnt++;
    chk_cnt++; if (if_pc !== 8'h00) $display("FAIL rst_pc: got %h want 00", if_pc); else pass_cnt++;
    chk_cnt++; if (if_halted !== 1'b0) $display("FAIL rst_halted: got %0b want 0", if_halted); else pass_cnt++;
  endtask

  task automatic test_basic();
    id_ready = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk_cnt++; if (imem_req !== 1'b1) $display("FAIL basic_req0: got %0b want 1", imem_req); else pass_cnt++;
    chk_cnt++; if (imem_addr !== 8'h00) $display("FAIL basic_addr0: got %h want 00", imem_addr); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if (imem_req !== 1'b0) $display("FAIL basic_wait_req: got %0b want 0", imem_req); else pass_cnt++;
    chk_cnt++; if (if_valid !== 1'b0) $display("FAIL basic_nobypass: got %0b want 0", if_valid); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if (if_valid !== 1'b1) $display("FAIL basic_valid0: got %0b want 1", if_valid); else pass_cnt++;
    chk_cnt++; if (if_instruction !== 16'h1234) $display("FAIL basic_instr0: got %h want 1234", if_instruction); else pass_cnt++;
    chk_cnt++; if (if_pc !== 8'h00) $display("FAIL basic_pc0: got %h want 00", if_pc); else pass_cnt++;
    chk_cnt++; if (imem_addr !== 8'h01) $display("FAIL basic_addr1: got %h want 01", imem_addr); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if (if_valid !== 1'b0) $display("FAIL basic_gap: got %0b want 0", if_valid); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if (if_instruction !== 16'h5678) $display("FAIL basic_instr1: got %h want 5678", if_instruction); else pass_cnt++;
    chk_cnt++; if (if_pc !== 8'h01) $display("FAIL basic_pc1: got %h want 01", if_pc); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    logic [23:0] exp_a [4];
    exp_a[0] = 24'h015678; exp_a[1] = 24'h02A502; exp_a[2] = 24'h03A503; exp_a[3] = 24'h04A504;
    id_ready = 1'b0; grant_q.delete();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk_cnt++; if ({if_pc, if_instruction} !== 24'h015678) $display("FAIL bp_stable: got %h want 015678", {if_pc, if_instruction}); else pass_cnt++;
    end
    chk_cnt++; if (imem_req !== 1'b0) $display("FAIL bp_req: got %0b want 0", imem_req); else pass_cnt++;
    chk_cnt++; if (grant_q.size() != 1) $display("FAIL bp_buffered: got %0d want 1 extra fetch", grant_q.size()); else pass_cnt++;
    cons_q.delete(); id_ready = 1'b1;
    for (int i = 0; i < 60 && cons_q.size() < 4; i++) @(negedge clk);
    chk_cnt++; if (cons_q.size() < 4) $display("FAIL bp_drain_cnt: got %0d want 4", cons_q.size()); else pass_cnt++;
    for (int i = 0; i < 4 && i < cons_q.size(); i++) begin
      chk_cnt++; if (cons_q[i] !== exp_a[i]) $display("FAIL bp_order%0d: got %h want %h", i, cons_q[i], exp_a[i]); else pass_cnt++;
    end
  endtask

  task automatic test_gnt_stall();
    gnt_en = 1'b0;
    repeat (8) @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 8'h20;
    @(negedge clk);
    redirect_valid = 1'b0; cons_q.delete(); grant_q.delete();
    for (int i = 0; i < 5; i++) begin
      chk_cnt++; if ({imem_req, imem_addr} !== 9'h120) $display("FAIL stall_hold%0d: got %h want 120", i, {imem_req, imem_addr}); else pass_cnt++;
      @(negedge clk);
    end
    gnt_en = 1'b1;
    for (int i = 0; i < 40 && cons_q.size() < 1; i++) @(negedge clk);
    chk_cnt++; if (cons_q.size() < 1 || cons_q[0] !== 24'h20A520) $display("FAIL stall_resume: got %0d entries want 20A520 first", cons_q.size()); else pass_cnt++;
  endtask

  task automatic test_redirect_wait();
    int gs;
    extra_lat = 3; gs = grant_q.size();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (grant_q.size() > gs) break;
    end
    chk_cnt++; if (grant_q.size() <= gs) $display("FAIL rdw_grant: got %0d want >%0d", grant_q.size(), gs); else pass_cnt++;
    redirect_valid = 1'b1; redirect_pc = 8'h40;
    @(negedge clk);
    redirect_valid = 1'b0; cons_q.delete(); grant_q.delete(); extra_lat = 0;
    chk_cnt++; if (if_valid !== 1'b0) $display("FAIL rdw_flush: got %0b want 0", if_valid); else pass_cnt++;
    chk_cnt++; if (imem_req !== 1'b0) $display("FAIL rdw_drain_req: got %0b want 0", imem_req); else pass_cnt++;
    for (int i = 0; i < 40 && cons_q.size() < 1; i++) @(negedge clk);
    chk_cnt++; if (cons_q.size() < 1 || cons_q[0] !== 24'h40A540) $display("FAIL rdw_first: got %0d entries want 40A540 first", cons_q.size()); else pass_cnt++;
    chk_cnt++; if (grant_q.size() < 1 || grant_q[0] !== 8'h40) $display("FAIL rdw_addr: got %0d grants want first 40", grant_q.size()); else pass_cnt++;
  endtask

  task automatic test_wrap();
    logic [23:0] exp_a [3];
    exp_a[0] = 24'hFEA5FE; exp_a[1] = 24'hFFA5FF; exp_a[2] = 24'h001234;
    redirect_valid = 1'b1; redirect_pc = 8'hFE;
    @(negedge clk);
    redirect_valid = 1'b0; cons_q.delete(); grant_q.delete();
    for (int i = 0; i < 60 && cons_q.size() < 3; i++) @(negedge clk);
    chk_cnt++; if (cons_q.size() < 3) $display("FAIL wrap_cnt: got %0d want 3", cons_q.size()); else pass_cnt++;
    for (int i = 0; i < 3 && i < cons_q.size(); i++) begin
      chk_cnt++; if (cons_q[i] !== exp_a[i]) $display("FAIL wrap%0d: got %h want %h", i, cons_q[i], exp_a[i]); else pass_cnt++;
    end
    chk_cnt++; if (grant_q.size() < 3 || grant_q[2] !== 8'h00) $display("FAIL wrap_addr: got %0d grants want third 00", grant_q.size()); else pass_cnt++;
  endtask

  task automatic test_halt();
    logic bad;
    mem[3] = 16'hF000;
    redirect_valid = 1'b1; redirect_pc = 8'h00;
    @(negedge clk);
    redirect_valid = 1'b0; cons_q.delete(); grant_q.delete();
`ifdef IF_HALT_DETECT_EN
    for (int i = 0; i < 60 && !if_halted; i++) @(negedge clk);
    repeat (10) @(negedge clk);
    chk_cnt++; if (if_halted !== 1'b1) $display("FAIL halt_flag: got %0b want 1", if_halted); else pass_cnt++;
    chk_cnt++; if (imem_req !== 1'b0) $display("FAIL halt_req: got %0b want 0", imem_req); else pass_cnt++;
    chk_cnt++; if (cons_q.size() != 4 || cons_q[3] !== 24'h03F000) $display("FAIL halt_drain: got %0d entries want 4 ending 03F000", cons_q.size()); else pass_cnt++;
    bad = 1'b0;
    foreach (grant_q[i]) if (grant_q[i] >= 8'h05) bad = 1'b1;
    chk_cnt++; if (bad !== 1'b0) $display("FAIL halt_noreq: got %0b want 0 (request at addr>=5)", bad); else pass_cnt++;
    redirect_valid = 1'b1; redirect_pc = 8'h10;
    @(negedge clk);
    redirect_valid = 1'b0; cons_q.delete();
    chk_cnt++; if (if_halted !== 1'b0) $display("FAIL halt_clear: got %0b want 0", if_halted); else pass_cnt++;
    for (int i = 0; i < 40 && cons_q.size() < 1; i++) @(negedge clk);
    chk_cnt++; if (cons_q.size() < 1 || cons_q[0] !== 24'h10A510) $display("FAIL halt_resume: got %0d entries want 10A510 first", cons_q.size()); else pass_cnt++;
`else
    bad = 1'b0;
    for (int i = 0; i < 60 && cons_q.size() < 6; i++) @(negedge clk);
    chk_cnt++; if (cons_q.size() < 6) $display("FAIL nohalt_cnt: got %0d want 6", cons_q.size()); else pass_cnt++;
    chk_cnt++; if (cons_q.size() < 6 || cons_q[3] !== 24'h03F000 || cons_q[5] !== 24'h05A505) $display("FAIL nohalt_seq: got %0d entries want 03F000 then 05A505", cons_q.size()); else pass_cnt++;
    chk_cnt++; if (if_halted !== bad) $display("FAIL nohalt_flag: got %0b want 0", if_halted); else pass_cnt++;
`endif
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_cnt++; if (imem_req !== 1'b0) $display("FAIL mid_rst_req: got %0b want 0", imem_req); else pass_cnt++;
    chk_cnt++; if (if_valid !== 1'b0) $display("FAIL mid_rst_valid: got %0b want 0", if_valid); else pass_cnt++;
    chk_cnt++; if (imem_addr !== 8'h00) $display("FAIL mid_rst_addr: got %h want 00", imem_addr); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    chk_cnt = 0; pass_cnt = 0;
    for (int i = 0; i < 256; i++) mem[i] = {8'hA5, 8'(i)};
    mem[0] = 16'h1234; mem[1] = 16'h5678;
    test_reset();
    test_basic();
    test_backpressure();
    test_gnt_stall();
    test_redirect_wait();
    test_wrap();
    test_halt();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
